// File: rtl/netwalk_match_encoder.sv
// -----------------------------------------------------------------------------
// netwalk_match_encoder
//
// Turns a multi-hot match vector into a stream of hit indices, one beat per
// set bit, in ascending index order. A vector with no bits set produces a
// single "miss" beat (index 0, out_miss=1, out_last=1).
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   in_valid   : match vector offered
//   in_ready   : encoder idle and able to take a vector
//   match_vec  : ENC_IN_WIDTH match lines, bit i = entry i hit
//   flush      : drop the remaining beats of the vector being emitted
//   out_valid  : index beat valid
//   out_ready  : downstream takes the beat
//   out_index  : hit index of this beat
//   out_seq    : beat number within the vector (0 for the first)
//   out_last   : final beat of the vector
//   out_miss   : vector had no bits set
// -----------------------------------------------------------------------------
module netwalk_match_encoder #(
    parameter  int ENC_OUT_WIDTH = 8,
    localparam int ENC_IN_WIDTH  = 1 << ENC_OUT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ENC_IN_WIDTH-1:0]  match_vec,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENC_OUT_WIDTH-1:0] out_index,
    output logic [ENC_OUT_WIDTH-1:0] out_seq,
    output logic                     out_last,
    output logic                     out_miss
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [ENC_IN_WIDTH-1:0] VEC_ONE = {{(ENC_IN_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state;
    state_t                    state_nxt;
    logic [ENC_IN_WIDTH-1:0]   pending;

    logic [ENC_IN_WIDTH-1:0]   src_vec;
    logic [ENC_IN_WIDTH-1:0]   rest_vec;
    logic [ENC_OUT_WIDTH-1:0]  lsb_idx;
    logic                      accept;
    logic                      emit_flush;
    logic                      emit_hs;

    // Lowest set bit; scanning from the top lets the last hit win. Returns 0
    // for an all-zero vector, which is exactly the index a miss beat carries.
    function automatic logic [ENC_OUT_WIDTH-1:0] lowest_set(input logic [ENC_IN_WIDTH-1:0] v);
        logic [ENC_OUT_WIDTH-1:0] idx;
        idx = '0;
        for (int i = ENC_IN_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = i[ENC_OUT_WIDTH-1:0];
        end
        return idx;
    endfunction

    // One shared encoder: in IDLE it looks at the incoming vector, in EMIT at
    // what is still pending. match_vec is therefore ignored during EMIT.
    always_comb begin
        src_vec  = (state == IDLE) ? match_vec : pending;
        lsb_idx  = lowest_set(src_vec);
        // v & (v-1) clears the lowest set bit.
        rest_vec = src_vec & (src_vec - VEC_ONE);
    end

    // Flush outranks the output handshake, which outranks accept. Flush in
    // IDLE does nothing except block acceptance that cycle.
    always_comb begin
        accept     = in_valid && in_ready && !flush;
        emit_flush = (state == EMIT) && flush;
        emit_hs    = (state == EMIT) && !flush && out_ready;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EMIT;
            EMIT: begin
                if (emit_flush)               state_nxt = IDLE;
                else if (emit_hs && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated by reset so in_ready is low while reset is held, even before the
    // first clock edge has put the state register into IDLE.
    always_comb begin
        in_ready = reset && (state == IDLE);
    end

    // ---------------- beat datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_seq   <= '0;
            out_last  <= 1'b0;
            out_miss  <= 1'b0;
        end else if (emit_flush) begin
            pending   <= '0;
            out_valid <= 1'b0;
        end else if (emit_hs) begin
            if (out_last) begin
                out_valid <= 1'b0;
            end else begin
                out_index <= lsb_idx;
                pending   <= rest_vec;
                out_seq   <= out_seq + 1'b1;
                out_last  <= (rest_vec == '0);
            end
        end else if (accept) begin
            out_index <= lsb_idx;
            pending   <= rest_vec;
            out_seq   <= '0;
            out_last  <= (rest_vec == '0);
            out_miss  <= (match_vec == '0);
            out_valid <= 1'b1;
        end
    end

endmodule
